arithmetic_logic_unit: RTL and testbench

ARITHMETIC_LOGIC_UNIT -- requirements
Module: arithmetic_logic_unit

---
 rtl/arithmetic_logic_unit.sv | 108 ++++++++++
 tb/tb_arithmetic_logic_unit.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arithmetic_logic_unit.sv
// Purpose     : registered ALU, 16 operations selected by 'control', with a signed-overflow flag.
// Latency     : 1 cycle; result and flag are captured together on every rising clk edge.
// Backpressure: none; a new operation is accepted every cycle and there is no stall path.
//
// Ports:
//   a        [BUS_WIDTH-1:0]  operand A; its low log2(BUS_WIDTH) bits give the shift amount
//   b        [BUS_WIDTH-1:0]  operand B; the value being shifted by SLL/SRL/SRA
//   control  [3:0]            operation select (see op_e)
//   clk                       rising-edge clock
//   reset                     asynchronous active-low reset; clears out and overflow
//   out      [BUS_WIDTH-1:0]  registered result
//   overflow                  registered signed overflow (ADD/SUB only)

module arithmetic_logic_unit #(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] a,
  input  logic [BUS_WIDTH-1:0] b,
  input  logic [3:0]           control,
  input  logic                 clk,
  input  logic                 reset,
  output logic [BUS_WIDTH-1:0] out,
  output logic                 overflow
);

  localparam int SH_W = $clog2(BUS_WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_XOR  = 4'd2,
    OP_OR   = 4'd3,
    OP_AND  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLTU = 4'd7,
    OP_SLL  = 4'd8,
    OP_SRL  = 4'd9,
    OP_SRA  = 4'd10,
    OP_PASA = 4'd11,
    OP_PASB = 4'd12,
    OP_ADDU = 4'd13,
    OP_SUBU = 4'd14,
    OP_ZERO = 4'd15
  } op_e;

  logic [BUS_WIDTH-1:0] out_d, out_q;
  logic                 ovf_d, ovf_q;

  logic [BUS_WIDTH-1:0] sum;
  logic [BUS_WIDTH-1:0] diff;
  logic [SH_W-1:0]      sh;
  logic                 slt_res;
  logic                 sltu_res;
  logic                 add_ovf;
  logic                 sub_ovf;
  op_e                  op;

  assign op   = op_e'(control);
  assign sum  = a + b;   // carry-out discarded: wraps modulo 2^BUS_WIDTH
  assign diff = a - b;
  assign sh   = a[SH_W-1:0];

  assign slt_res  = $signed(a) < $signed(b);
  assign sltu_res = a < b;

  // Signed overflow from sign bits only; ADDU/SUBU share the adder but never flag.
  assign add_ovf = (a[BUS_WIDTH-1] == b[BUS_WIDTH-1]) && (sum[BUS_WIDTH-1]  != a[BUS_WIDTH-1]);
  assign sub_ovf = (a[BUS_WIDTH-1] != b[BUS_WIDTH-1]) && (diff[BUS_WIDTH-1] != a[BUS_WIDTH-1]);

  always_comb begin
    out_d = '0;
    ovf_d = 1'b0;
    unique case (op)
      OP_ADD:  begin out_d = sum;  ovf_d = add_ovf; end
      OP_SUB:  begin out_d = diff; ovf_d = sub_ovf; end
      OP_XOR:  out_d = a ^ b;
      OP_OR:   out_d = a | b;
      OP_AND:  out_d = a & b;
      OP_NOR:  out_d = ~(a | b);
      OP_SLT:  out_d = {{(BUS_WIDTH-1){1'b0}}, slt_res};
      OP_SLTU: out_d = {{(BUS_WIDTH-1){1'b0}}, sltu_res};
      OP_SLL:  out_d = b << sh;
      OP_SRL:  out_d = b >> sh;
      OP_SRA:  out_d = $unsigned($signed(b) >>> sh);
      OP_PASA: out_d = a;
      OP_PASB: out_d = b;
      OP_ADDU: out_d = sum;
      OP_SUBU: out_d = diff;
      OP_ZERO: out_d = '0;
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign out      = out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
module tb_arithmetic_logic_unit;

  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic        clk;
  logic        reset;
  logic [31:0] out;
  logic        overflow;

  int vectors;
  int miscompares;

  arithmetic_logic_unit #(.BUS_WIDTH(32)) dut (
    .a        (a),
    .b        (b),
    .control  (control),
    .clk      (clk),
    .reset    (reset),
    .out      (out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs on the falling edge, well away from the capturing edge.
  task automatic drive(input logic [31:0] av, input logic [31:0] bv, input logic [3:0] cv);
    @(negedge clk);
    a       = av;
    b       = bv;
    control = cv;
  endtask

  // Advance past one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (out !== 32'h0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_async: out=%h ovf=%b required out=00000000 ovf=0", out, overflow);
    end
    // Edges while held in reset must not update the outputs.
    drive(32'h7FFF_FFFF, 32'h1, 4'd0);
    step();
    step();
    vectors++;
    if (out !== 32'h0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: out=%h ovf=%b required out=00000000 ovf=0", out, overflow);
    end
    // First edge after release reflects inputs present at that edge.
    drive(32'h5, 32'h3, 4'd0);
    reset = 1'b1;
    #1;
    vectors++;
    if (out !== 32'h0) begin
      miscompares++;
      $display("FAIL add_before_edge: out=%h required 00000000", out);
    end
    step();
    vectors++;
    if (out !== 32'h8 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL add_basic: out=%h ovf=%b required out=00000008 ovf=0", out, overflow);
    end
  endtask

  task automatic test_add_overflow();
    drive(32'h7FFF_FFFF, 32'h1, 4'd0);
    step();
    vectors++;
    if (out !== 32'h8000_0000 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL add_ovf: out=%h ovf=%b required out=80000000 ovf=1", out, overflow);
    end
    drive(32'h7FFF_FFFF, 32'h1, 4'd13);
    step();
    vectors++;
    if (out !== 32'h8000_0000 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL addu_no_ovf: out=%h ovf=%b required out=80000000 ovf=0", out, overflow);
    end
    // Negative + negative wrapping to zero.
    drive(32'h8000_0000, 32'h8000_0000, 4'd0);
    step();
    vectors++;
    if (out !== 32'h0 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL add_neg_ovf: out=%h ovf=%b required out=00000000 ovf=1", out, overflow);
    end
  endtask

  task automatic test_logic();
    drive(32'hFFFF_FFF0, 32'h0000_00FF, 4'd4);
    step();
    vectors++;
    if (out !== 32'h0000_00F0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL and: out=%h ovf=%b required out=000000f0 ovf=0", out, overflow);
    end
    drive(32'hFFFF_FFF0, 32'h0000_00FF, 4'd3);
    step();
    vectors++;
    if (out !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL or: out=%h required ffffffff", out);
    end
    drive(32'hFFFF_FFF0, 32'h0000_00FF, 4'd5);
    step();
    vectors++;
    if (out !== 32'h0) begin
      miscompares++;
      $display("FAIL nor: out=%h required 00000000", out);
    end
    drive(32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
    step();
    vectors++;
    if (out !== 32'h0FF0_0FF0) begin
      miscompares++;
      $display("FAIL xor: out=%h required 0ff00ff0", out);
    end
  endtask

  task automatic test_sub_slt();
    drive(32'hFFFF_FFFF, 32'h1, 4'd1);
    step();
    vectors++;
    if (out !== 32'hFFFF_FFFE || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL sub: out=%h ovf=%b required out=fffffffe ovf=0", out, overflow);
    end
    drive(32'hFFFF_FFFF, 32'h1, 4'd6);
    step();
    vectors++;
    if (out !== 32'h1) begin
      miscompares++;
      $display("FAIL slt: out=%h required 00000001", out);
    end
    drive(32'hFFFF_FFFF, 32'h1, 4'd7);
    step();
    vectors++;
    if (out !== 32'h0) begin
      miscompares++;
      $display("FAIL sltu: out=%h required 00000000", out);
    end
    drive(32'h8000_0000, 32'h1, 4'd1);
    step();
    vectors++;
    if (out !== 32'h7FFF_FFFF || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL sub_ovf: out=%h ovf=%b required out=7fffffff ovf=1", out, overflow);
    end
    drive(32'h8000_0000, 32'h1, 4'd14);
    step();
    vectors++;
    if (out !== 32'h7FFF_FFFF || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL subu: out=%h ovf=%b required out=7fffffff ovf=0", out, overflow);
    end
    drive(32'h0000_0001, 32'hFFFF_FFFF, 4'd7);
    step();
    vectors++;
    if (out !== 32'h1) begin
      miscompares++;
      $display("FAIL sltu_true: out=%h required 00000001", out);
    end
  endtask

  task automatic test_shifts();
    drive(32'h4, 32'h8000_0010, 4'd8);
    step();
    vectors++;
    if (out !== 32'h0000_0100) begin
      miscompares++;
      $display("FAIL sll: out=%h required 00000100", out);
    end
    drive(32'h4, 32'h8000_0010, 4'd9);
    step();
    vectors++;
    if (out !== 32'h0800_0001) begin
      miscompares++;
      $display("FAIL srl: out=%h required 08000001", out);
    end
    drive(32'h4, 32'h8000_0010, 4'd10);
    step();
    vectors++;
    if (out !== 32'hF800_0001) begin
      miscompares++;
      $display("FAIL sra: out=%h required f8000001", out);
    end
    // Upper bits of a are ignored: 0xFFFFFFE4 shifts by 4.
    drive(32'hFFFF_FFE4, 32'h8000_0010, 4'd9);
    step();
    vectors++;
    if (out !== 32'h0800_0001) begin
      miscompares++;
      $display("FAIL srl_upper_ignored: out=%h required 08000001", out);
    end
    drive(32'd31, 32'h1, 4'd8);
    step();
    vectors++;
    if (out !== 32'h8000_0000) begin
      miscompares++;
      $display("FAIL sll_max: out=%h required 80000000", out);
    end
  endtask

  task automatic test_pass_zero();
    drive(32'hDEAD_BEEF, 32'h1234_5678, 4'd11);
    step();
    vectors++;
    if (out !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL pass_a: out=%h required deadbeef", out);
    end
    drive(32'hDEAD_BEEF, 32'h1234_5678, 4'd12);
    step();
    vectors++;
    if (out !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL pass_b: out=%h required 12345678", out);
    end
    drive(32'hDEAD_BEEF, 32'h1234_5678, 4'd15);
    step();
    vectors++;
    if (out !== 32'h0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL zero: out=%h ovf=%b required out=00000000 ovf=0", out, overflow);
    end
  endtask

  task automatic test_hold();
    drive(32'h10, 32'h20, 4'd0);
    step();
    // Inputs change between edges; registered outputs must not follow.
    drive(32'h7FFF_FFFF, 32'h1, 4'd0);
    #1;
    vectors++;
    if (out !== 32'h30 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL hold_between_edges: out=%h ovf=%b required out=00000030 ovf=0", out, overflow);
    end
    step();
    vectors++;
    if (out !== 32'h8000_0000 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL hold_next_edge: out=%h ovf=%b required out=80000000 ovf=1", out, overflow);
    end
  endtask

  task automatic test_reset_midstream();
    drive(32'h7FFF_FFFF, 32'h1, 4'd0);
    step();
    vectors++;
    if (out !== 32'h8000_0000 || overflow !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: out=%h ovf=%b required out=80000000 ovf=1", out, overflow);
    end
    drive(32'h5, 32'h3, 4'd0);
    #2;
    reset = 1'b0;
    #1;
    vectors++;
    if (out !== 32'h0 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async_clear: out=%h ovf=%b required out=00000000 ovf=0", out, overflow);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (out !== 32'h0 || overflow !== 1'b0) begin
        miscompares++;
        $display("FAIL mid_hold_edge%0d: out=%h ovf=%b required out=00000000 ovf=0", i, out, overflow);
      end
    end
    drive(32'h10, 32'h20, 4'd0);
    reset = 1'b1;
    step();
    vectors++;
    if (out !== 32'h30 || overflow !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_release: out=%h ovf=%b required out=00000030 ovf=0", out, overflow);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    a           = 32'h0;
    b           = 32'h0;
    control     = 4'd0;
    test_reset();
    test_add_overflow();
    test_logic();
    test_sub_slt();
    test_shifts();
    test_pass_zero();
    test_hold();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
